div_sequencer: RTL

//  Sequences RISC-V M-extension DIV/DIVU/REM/REMU for the execute stage using an iterative restoring divider core.

---
 rtl/div_pkg.sv | 11 +
 rtl/div_iter_core.sv | 45 ++++
 rtl/div_sequencer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared op/state encodings and op decode helpers for the divide sequencer
package div_pkg;
  typedef enum logic [1:0] {OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11} op_e;
  typedef enum logic [2:0] {S_IDLE, S_PREP, S_RUN, S_FIX, S_DONE} state_e;
  function automatic logic is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction
  function automatic logic is_rem(input logic [1:0] op);
    return op[1];
  endfunction
endpackage

// File: rtl/div_iter_core.sv
// div_iter_core: unsigned restoring divider resolving B quotient bits per enabled cycle
module div_iter_core #(
  parameter int N = 32,
  parameter int B = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder
);
  logic [N-1:0] r_q, r_r, r_d, w_q, w_r;
  logic [N:0]   w_t, w_s;
  // r_q starts as the dividend and shifts quotient bits in from the bottom
  always_comb begin
    w_q = r_q;
    w_r = r_r;
    w_t = '0;
    w_s = '0;
    for (int i = 0; i < B; i++) begin
      w_t = {w_r, w_q[N-1]};
      w_s = w_t - {1'b0, r_d};
      w_q = {w_q[N-2:0], ~w_s[N]};
      w_r = w_s[N] ? w_t[N-1:0] : w_s[N-1:0];
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_q <= '0;
      r_r <= '0;
      r_d <= '0;
    end else if (load) begin
      r_q <= dividend;
      r_r <= '0;
      r_d <= divisor;
    end else if (en) begin
      r_q <= w_q;
      r_r <= w_r;
    end
  assign quotient  = r_q;
  assign remainder = r_r;
endmodule

// File: rtl/div_sequencer.sv
// div_sequencer: RISC-V DIV/DIVU/REM/REMU sequencer around an iterative restoring core
// Optional last-result cache enabled by defining DIV_RESULT_CACHE_EN.
module div_sequencer import div_pkg::*; #(
  parameter int N              = 32,
  parameter int BITS_PER_CYCLE = 4,
  parameter int TAG_W          = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [N-1:0]     req_rs1,
  input  logic [N-1:0]     req_rs2,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             kill,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [N-1:0]     resp_data,
  output logic [TAG_W-1:0] resp_tag
);
  localparam int STEPS = N / BITS_PER_CYCLE;
  localparam int CW = $clog2(STEPS + 1);
  localparam logic [N-1:0] MIN = {1'b1, {(N-1){1'b0}}};
  state_e           r_state, w_next;
  logic [1:0]       r_op;
  logic [N-1:0]     r_rs1, r_rs2, r_data;
  logic [TAG_W-1:0] r_tag;
  logic [CW-1:0]    r_cnt;
  logic             w_sgn, w_n1, w_n2, w_div0, w_ovf, w_hit, w_accept;
  logic [N-1:0]     w_a1, w_a2, w_cq, w_cr, w_fq, w_fr, w_sq, w_sr, w_hit_data;
  assign w_sgn  = is_signed(r_op);
  assign w_n1   = w_sgn & r_rs1[N-1];
  assign w_n2   = w_sgn & r_rs2[N-1];
  assign w_a1   = w_n1 ? -r_rs1 : r_rs1;
  assign w_a2   = w_n2 ? -r_rs2 : r_rs2;
  assign w_div0 = r_rs2 == '0;
  assign w_ovf  = w_sgn && r_rs1 == MIN && &r_rs2;
  assign w_sq   = w_div0 ? '1 : MIN;
  assign w_sr   = w_div0 ? r_rs1 : '0;
  assign w_fq   = (w_n1 ^ w_n2) ? -w_cq : w_cq;
  assign w_fr   = w_n1 ? -w_cr : w_cr;
  assign w_accept = r_state == S_IDLE && req_valid && !kill;
  div_iter_core #(.N(N), .B(BITS_PER_CYCLE)) u_core (
    .clk       (clk),
    .reset     (reset),
    .load      (r_state == S_PREP),
    .en        (r_state == S_RUN),
    .dividend  (w_a1),
    .divisor   (w_a2),
    .quotient  (w_cq),
    .remainder (w_cr)
  );
`ifdef DIV_RESULT_CACHE_EN
  logic         r_c_valid, r_c_sgn;
  logic [N-1:0] r_c_rs1, r_c_rs2, r_c_q, r_c_r;
  assign w_hit = r_c_valid && r_c_rs1 == req_rs1 && r_c_rs2 == req_rs2 && r_c_sgn == is_signed(req_op);
  assign w_hit_data = is_rem(req_op) ? r_c_r : r_c_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_c_valid <= 1'b0;
      r_c_sgn   <= 1'b0;
      r_c_rs1   <= '0;
      r_c_rs2   <= '0;
      r_c_q     <= '0;
      r_c_r     <= '0;
    end else if (kill) begin
      r_c_valid <= 1'b0;
    end else if (r_state == S_FIX) begin
      r_c_valid <= 1'b1;
      r_c_sgn   <= w_sgn;
      r_c_rs1   <= r_rs1;
      r_c_rs2   <= r_rs2;
      r_c_q     <= w_fq;
      r_c_r     <= w_fr;
    end
`else
  assign w_hit      = 1'b0;
  assign w_hit_data = '0;
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_state <= S_IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    if (kill) w_next = S_IDLE;
    else
      case (r_state)
        S_IDLE: if (req_valid) w_next = w_hit ? S_DONE : S_PREP;
        S_PREP: w_next = (w_div0 || w_ovf) ? S_DONE : S_RUN;
        S_RUN:  if (r_cnt == CW'(STEPS - 1)) w_next = S_FIX;
        S_FIX:  w_next = S_DONE;
        S_DONE: if (resp_ready) w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
  end
  // PREP always writes the special-case result; normal ops overwrite it in FIX
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_op   <= '0;
      r_rs1  <= '0;
      r_rs2  <= '0;
      r_tag  <= '0;
      r_data <= '0;
      r_cnt  <= '0;
    end else begin
      r_cnt <= (r_state == S_RUN) ? r_cnt + 1'b1 : '0;
      if (w_accept) begin
        r_op  <= req_op;
        r_rs1 <= req_rs1;
        r_rs2 <= req_rs2;
        r_tag <= req_tag;
        if (w_hit) r_data <= w_hit_data;
      end
      if (r_state == S_PREP) r_data <= is_rem(r_op) ? w_sr : w_sq;
      if (r_state == S_FIX) r_data <= is_rem(r_op) ? w_fr : w_fq;
    end
  assign req_ready  = r_state == S_IDLE;
  assign resp_valid = r_state == S_DONE;
  assign resp_data  = r_data;
  assign resp_tag   = r_tag;
endmodule
